// File: rtl/box_motion_scheduler.sv
// Per-frame motion scheduler for a bank of bouncing boxes: during vertical blanking it
// walks each box through one shared position/velocity/color update datapath.
module box_motion_scheduler #(
  parameter int NUM_BOXES     = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BOX_WIDTH     = 100,
  parameter int BOX_HEIGHT    = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               clr_overrun,
  input  logic [2:0]         rd_idx,
  output logic signed [10:0] rd_x,
  output logic signed [9:0]  rd_y,
  output logic [2:0]         rd_color,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

  localparam logic [2:0]         LAST_IDX = 3'(NUM_BOXES - 1);
  localparam logic signed [10:0] LX       = 11'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic signed [9:0]  LY       = 10'(SCREEN_HEIGHT - BOX_HEIGHT);

  state_t state, state_nxt;
  logic [2:0] idx;

  // Bank is sized for the full 3-bit index space so rd_idx never indexes out of range.
  logic signed [10:0] x_bank  [8];
  logic signed [10:0] vx_bank [8];
  logic signed [9:0]  y_bank  [8];
  logic signed [9:0]  vy_bank [8];
  logic [2:0]         c_bank  [8];

  logic signed [10:0] w_x, w_vx, tx, nx, nvx;
  logic signed [9:0]  w_y, w_vy, ty, ny, nvy;
  logic [2:0]         w_c, nc;
  logic               hit_x, hit_y;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick && enable) state_nxt = FETCH;
      FETCH:   state_nxt = UPDATE;
      UPDATE:  state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        idx <= '0;
      else if (state == UPDATE && idx != LAST_IDX)
        idx <= idx + 3'd1;
      // A tick while busy (DONE included) is dropped; setting beats clearing.
      if (frame_tick && busy)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  // Working copy is always loaded in FETCH before it is consumed, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      w_x  <= x_bank[idx];
      w_y  <= y_bank[idx];
      w_vx <= vx_bank[idx];
      w_vy <= vy_bank[idx];
      w_c  <= c_bank[idx];
    end
  end

  always_comb begin
    tx    = w_x + w_vx;
    ty    = w_y + w_vy;
    hit_x = tx[10] || (tx >= LX);
    hit_y = ty[9]  || (ty >= LY);
    nx    = tx[10] ? '0 : ((tx > LX) ? LX : tx);
    ny    = ty[9]  ? '0 : ((ty > LY) ? LY : ty);
    nvx   = hit_x ? -w_vx : w_vx;
    nvy   = hit_y ? -w_vy : w_vy;
    nc    = w_c;
    if (hit_x || hit_y) nc = (w_c == 3'd7) ? 3'd1 : w_c + 3'd1;
  end

  // NOTE: unlike a plain RAM, this bank holds each box's defined starting position,
  // so it sits on the asynchronous reset like any other architectural register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        x_bank[i]  <= 11'(50 + 100 * (i % 5));
        y_bank[i]  <= 10'(50 + 60 * (i % 6));
        vx_bank[i] <= (i % 2 == 0) ? 11'sd2 : -11'sd2;
        vy_bank[i] <= (i < 2) ? 10'sd1 : -10'sd1;
        c_bank[i]  <= 3'((i % 7) + 1);
      end
    end else if (state == UPDATE) begin
      x_bank[idx]  <= nx;
      y_bank[idx]  <= ny;
      vx_bank[idx] <= nvx;
      vy_bank[idx] <= nvy;
      c_bank[idx]  <= nc;
    end
  end

  always_comb begin
    rd_x     = '0;
    rd_y     = '0;
    rd_color = '0;
    if (int'(rd_idx) < NUM_BOXES) begin
      rd_x     = x_bank[rd_idx];
      rd_y     = y_bank[rd_idx];
      rd_color = c_bank[rd_idx];
    end
  end

endmodule

// File: tb/tb_box_motion_scheduler.sv
// Self-checking bench for box_motion_scheduler: directed timing/overrun/reset scenarios
// plus randomized frame sequences compared against an arithmetic model of the boxes.
module tb_box_motion_scheduler;

  localparam int N  = 4;
  localparam int LX = 540;
  localparam int LY = 380;

  logic               clk = 1'b0;
  logic               rst_n, frame_tick, enable, clr_overrun;
  logic [2:0]         rd_idx;
  logic signed [10:0] rd_x;
  logic signed [9:0]  rd_y;
  logic [2:0]         rd_color;
  logic               busy, done, overrun;

  int checks = 0;
  int errors = 0;
  int mx[8], my[8], mvx[8], mvy[8], mc[8];

  box_motion_scheduler #(.NUM_BOXES(N)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .clr_overrun(clr_overrun), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .rd_color(rd_color), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = 50 + 100 * (i % 5);
      my[i]  = 50 + 60 * (i % 6);
      mvx[i] = (i % 2 == 0) ? 2 : -2;
      mvy[i] = (i < 2) ? 1 : -1;
      mc[i]  = (i % 7) + 1;
    end
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < N; i++) begin
      int tx, ty;
      bit hx, hy;
      tx = mx[i] + mvx[i];
      ty = my[i] + mvy[i];
      hx = (tx < 0) || (tx >= LX);
      hy = (ty < 0) || (ty >= LY);
      mx[i] = (tx < 0) ? 0 : (tx > LX ? LX : tx);
      my[i] = (ty < 0) ? 0 : (ty > LY ? LY : ty);
      if (hx) mvx[i] = -mvx[i];
      if (hy) mvy[i] = -mvy[i];
      if (hx || hy) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
    end
  endfunction

  task automatic read_box(input int i, output logic signed [10:0] x,
                          output logic signed [9:0] y, output logic [2:0] c);
    rd_idx = 3'(i);
    #1;
    x = rd_x;
    y = rd_y;
    c = rd_color;
  endtask

  task automatic pulse_tick(input logic en);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    enable = en;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  // Returns at the falling edge inside the DONE cycle; a missing done is a failure.
  task automatic wait_done();
    bit seen = 0;
    int n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected a done pulse", n);
    end
  endtask

  task automatic test_reset();
    int ex[4] = '{50, 150, 250, 350};
    int ey[4] = '{50, 110, 170, 230};
    int ec[4] = '{1, 2, 3, 4};
    logic signed [10:0] bx;
    logic signed [9:0]  by;
    logic [2:0]         bc;
    rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; clr_overrun = 1'b0; rd_idx = '0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/overrun=%b, expected 000", {busy, done, overrun});
    end
    for (int i = 0; i < 4; i++) begin
      read_box(i, bx, by, bc);
      checks++;
      if (bx !== 11'(ex[i]) || by !== 10'(ey[i]) || bc !== 3'(ec[i])) begin
        errors++;
        $display("FAIL reset_box%0d: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                 i, bx, by, bc, ex[i], ey[i], ec[i]);
      end
    end
    model_reset();
  endtask

  task automatic test_single_tick();
    logic signed [10:0] bx;
    logic signed [9:0]  by;
    logic [2:0]         bc;
    int done_cnt = 0;
    pulse_tick(1'b1);
    for (int k = 1; k <= 2 * N + 2; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      checks++;
      if (busy !== (k <= 2 * N + 1) || done !== (k == 2 * N + 1)) begin
        errors++;
        $display("FAIL tick_timing cycle t+%0d: busy=%b done=%b, expected busy=%b done=%b",
                 k, busy, done, k <= 2 * N + 1, k == 2 * N + 1);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_count: %0d pulses, expected 1", done_cnt);
    end
    model_frame();
    read_box(0, bx, by, bc);
    checks++;
    if (bx !== 11'sd52 || by !== 10'sd51 || bc !== 3'd1) begin
      errors++;
      $display("FAIL first_frame_box0: got (%0d,%0d,%0d), expected (52,51,1)", bx, by, bc);
    end
  endtask

  task automatic test_overrun();
    logic signed [10:0] bx;
    logic signed [9:0]  by;
    logic [2:0]         bc;
    // Second tick two cycles in; enable also falls mid-sequence.
    pulse_tick(1'b1);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b, expected 1", overrun);
    end
    wait_done();
    model_frame();
    for (int i = 0; i < N; i++) begin
      read_box(i, bx, by, bc);
      checks++;
      if (bx !== 11'(mx[i]) || by !== 10'(my[i]) || bc !== 3'(mc[i])) begin
        errors++;
        $display("FAIL enable_drop_box%0d: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                 i, bx, by, bc, mx[i], my[i], mc[i]);
      end
    end
    // Tick in the DONE cycle: ignored, but flags overrun.
    pulse_tick(1'b1);
    wait_done();
    model_frame();
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle_tick: busy=%b overrun=%b, expected busy=0 overrun=1", busy, overrun);
    end
    // Clear together with a fresh overrun tick: set wins.
    pulse_tick(1'b1);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    clr_overrun = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: overrun=%b, expected 1", overrun);
    end
    wait_done();
    model_frame();
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, expected 0", overrun);
    end
  endtask

  task automatic test_random_frames();
    logic signed [10:0] bx;
    logic signed [9:0]  by;
    logic [2:0]         bc;
    for (int it = 0; it < 900; it++) begin
      int gap = $urandom_range(0, 4);
      repeat (gap) @(posedge clk);
      if ($urandom_range(0, 9) == 0) begin
        pulse_tick(1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL disabled_tick it=%0d: busy=%b overrun=%b, expected 0/0", it, busy, overrun);
        end
      end else begin
        int px = mx[0], pvx = mvx[0], pc = mc[0];
        pulse_tick(1'b1);
        wait_done();
        model_frame();
        for (int i = 0; i < N; i++) begin
          read_box(i, bx, by, bc);
          checks++;
          if (bx !== 11'(mx[i]) || by !== 10'(my[i]) || bc !== 3'(mc[i])) begin
            errors++;
            $display("FAIL frame it=%0d box%0d: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                     it, i, bx, by, bc, mx[i], my[i], mc[i]);
          end
        end
        if (px == 538 && pvx == 2) begin
          read_box(0, bx, by, bc);
          checks++;
          if (bx !== 11'sd540 || bc !== 3'((pc == 7) ? 1 : pc + 1)) begin
            errors++;
            $display("FAIL right_edge: got x=%0d c=%0d, expected x=540 c=%0d",
                     bx, bc, (pc == 7) ? 1 : pc + 1);
          end
        end
        if (px == 2 && pvx == -2) begin
          read_box(0, bx, by, bc);
          checks++;
          if (bx !== 11'sd0) begin
            errors++;
            $display("FAIL left_edge: got x=%0d, expected 0", bx);
          end
        end
        read_box($urandom_range(N, 7), bx, by, bc);
        checks++;
        if (bx !== 11'sd0 || by !== 10'sd0 || bc !== 3'd0) begin
          errors++;
          $display("FAIL out_of_range_read idx=%0d: got (%0d,%0d,%0d), expected zeros",
                   rd_idx, bx, by, bc);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic signed [10:0] bx;
    logic signed [9:0]  by;
    logic [2:0]         bc;
    pulse_tick(1'b1);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_flags: busy/done/overrun=%b, expected 000", {busy, done, overrun});
    end
    model_reset();
    for (int i = 0; i < N; i++) begin
      read_box(i, bx, by, bc);
      checks++;
      if (bx !== 11'(mx[i]) || by !== 10'(my[i]) || bc !== 3'(mc[i])) begin
        errors++;
        $display("FAIL async_reset_box%0d: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                 i, bx, by, bc, mx[i], my[i], mc[i]);
      end
    end
    #1 rst_n = 1'b1;
    pulse_tick(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL enable_low_tick: busy=%b overrun=%b, expected 0/0", busy, overrun);
      end
    end
    read_box(5, bx, by, bc);
    checks++;
    if (bx !== 11'sd0 || by !== 10'sd0 || bc !== 3'd0) begin
      errors++;
      $display("FAIL read_idx5: got (%0d,%0d,%0d), expected zeros", bx, by, bc);
    end
  endtask

  initial begin
    test_reset();
    test_single_tick();
    test_overrun();
    test_random_frames();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
